digit_sequence_game: RTL
========================

// Module: digit_sequence_game
// PURPOSE
//   Memory-game core: consumes the 0-9 stream from random_digit and appends one digit per round.
//   Plays the sequence back on one 7-segment digit, then checks the player's keyed entries.
//   Sits between random_digit (upstream) and the 7-segment encoder/mux (downstream).
//   Keypad input comes from the debounced key decoder.
// PARAMETERS
//   MAX_LEN        16  sequence length that wins the game (1..64)
//   SHOW_TICKS     4   ticks each digit is shown during playback (>=1)
//   GAP_TICKS      1   blank ticks between shown digits (>=1)
//   TIMEOUT_TICKS  20  ticks allowed per key in INPUT (used only with INPUT_TIMEOUT_EN)
// PORTS
//   clk         in   1      system clock; single clock domain
//   reset       in   1      synchronous, active-high reset
//   tick        in   1      one-cycle pulse from the game prescaler; paces SHOW/GAP (and timeout)
//   rnd_digit   in   4      random digit from random_digit, sampled in ADD
//   start       in   1      one-cycle pulse: start a game, or restart from WIN/FAIL
//   key_valid   in   1      one-cycle pulse: key_digit is a new player entry
//   key_digit   in   4      player digit, 0-9
//   disp_digit  out  4      digit for the 7-segment encoder
//   disp_blank  out  1      1 = display dark
//   level       out  LEN_W  current sequence length; LEN_W = $clog2(MAX_LEN+1)
//   busy        out  1      1 while in ADD, SHOW or GAP (playback; keys ignored)
//   win         out  1      sticky, 1 in WIN
//   fail        out  1      sticky, 1 in FAIL
// BEHAVIOUR
//   Reset (sampled on posedge clk):
//     state=IDLE, len=0, idx=0, tick_cnt=0;
//     disp_digit=0, disp_blank=1, level=0, busy=0, win=0, fail=0.
//     Reset mid-game discards the sequence; state is IDLE on the next cycle.
//   All outputs are registered; every state change takes effect on the cycle after its trigger.
//   States:
//     IDLE -> ADD on start.
//     ADD (1 cycle):
//       - mem[len] <= rnd_digit; a value >9 is stored as rnd_digit-10.
//       - len <= len+1; idx <= 0; tick_cnt <= 0; -> SHOW.
//     SHOW:
//       - disp_digit = mem[idx], disp_blank = 0.
//       - Count ticks; on the SHOW_TICKS-th tick -> GAP with tick_cnt cleared.
//     GAP:
//       - disp_blank = 1.
//       - On the GAP_TICKS-th tick: if idx==len-1 then idx <= 0, -> INPUT;
//         else idx <= idx+1, -> SHOW.
//     INPUT (on key_valid):
//       - Echo: disp_digit = key_digit, disp_blank = 0.
//       - Match (key_digit==mem[idx]):
//         - idx <  len-1: idx <= idx+1.
//         - idx == len-1 and len <  MAX_LEN: -> ADD (next round).
//         - idx == len-1 and len == MAX_LEN: -> WIN.
//       - Mismatch, or key_digit > 9: -> FAIL.
//     WIN / FAIL:
//       - disp_blank = 1; win/fail held until start or reset.
//       - start clears win/fail, len=0, -> ADD.
//   Ignored events:
//     - start in ADD/SHOW/GAP/INPUT.
//     - key_valid outside INPUT.
//     - tick outside SHOW/GAP (INPUT: see CONFIGURATION).
//   Simultaneous events:
//     - start and key_valid in INPUT: key is processed, start is ignored.
//     - tick and key_valid in the same cycle in INPUT: key is processed first.
//   level == len at all times; len never exceeds MAX_LEN.
// CONFIGURATION
//   INPUT_TIMEOUT_EN defined:
//     - In INPUT, tick_cnt counts ticks and is cleared on every accepted key.
//     - Reaching TIMEOUT_TICKS -> FAIL.
//     - When a key and the final tick coincide, the key wins.
//   INPUT_TIMEOUT_EN undefined: INPUT waits indefinitely; timeout logic is absent.
// STRUCTURE
//   game_defs.vh (shared include):
//     - State localparams: IDLE, ADD, SHOW, GAP, INPUT, WIN, FAIL.
//     - DIGIT_W=4 and DIGIT_MAX=9, shared with random_digit and the display encoder.
//   Sub-module seq_mem: MAX_LEN x 4 register file; one sync write port, one async read port (idx).
//     - No reset on contents; only len qualifies them.
//   Top level: FSM, idx/len/tick_cnt counters, output registers.
// TESTING
//   1. reset 3 cycles -> disp_blank=1, level=0, win=fail=busy=0; key_valid ignored.
//   2. start, rnd_digit=7, SHOW_TICKS=4 -> disp_digit=7 unblanked for 4 ticks, blank 1 tick, INPUT;
//      key 7 -> level=2 with busy=1.
//   3. Round 2 with mem={7,3}: keys 7 then 5 -> fail=1 next cycle, disp_blank=1;
//      start -> fail=0, level=1.
//   4. MAX_LEN=2, rnd 4 then 12 (stored as 2): correct keys 4, 4, 2 -> win=1, level=2;
//      keys ignored afterwards.
//   5. Reset asserted mid-SHOW at level 3 -> next cycle IDLE, level=0, disp_blank=1.
//   6. INPUT_TIMEOUT_EN, TIMEOUT_TICKS=3: no key for 3 ticks -> fail=1;
//      key on the 3rd tick with the correct digit -> no fail.

Source files
------------

// File: rtl/digit_sequence_game_pkg.sv
// Shared definitions for the digit sequence game: state encoding, digit width
// and the fold that maps a raw 4-bit random value onto 0-9.
package digit_sequence_game_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_SHOW  = 3'd2,
    S_GAP   = 3'd3,
    S_INPUT = 3'd4,
    S_WIN   = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  // Values 10..15 from the random source are stored as value-10.
  function automatic logic [DIGIT_W-1:0] fold_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(DIGIT_MAX)) ? d - DIGIT_W'(10) : d;
  endfunction

endpackage

// File: rtl/digit_sequence_game_seq_mem.sv
// Sequence storage: DEPTH x DIGIT_W register file, one synchronous write port
// and one asynchronous read port. Contents are not reset; the game length
// decides which entries are meaningful.
module digit_sequence_game_seq_mem
  import digit_sequence_game_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [DIGIT_W-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [DIGIT_W-1:0] o_rd_data
);

  logic [DIGIT_W-1:0] r_mem [DEPTH];

  // Write one digit per ADD cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/digit_sequence_game.sv
// Memory-game core: grows a digit sequence one round at a time, plays it back
// on a single 7-segment digit and checks the player's keyed entries.
// Optional feature macro: INPUT_TIMEOUT_EN (per-key tick timeout in INPUT).
//
//   state   | meaning
//   S_IDLE  | waiting for the first start
//   S_ADD   | append one random digit, one cycle
//   S_SHOW  | display mem[idx] for SHOW_TICKS ticks
//   S_GAP   | dark for GAP_TICKS ticks between shown digits
//   S_INPUT | compare player keys against the sequence
//   S_WIN   | full MAX_LEN sequence entered, waits for start
//   S_FAIL  | wrong key (or timeout), waits for start
module digit_sequence_game
  import digit_sequence_game_pkg::*;
#(
  parameter int MAX_LEN       = 16,
  parameter int SHOW_TICKS    = 4,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 20,
  localparam int LEN_W        = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [DIGIT_W-1:0] i_rnd_digit,
  input  logic               i_start,
  input  logic               i_key_valid,
  input  logic [DIGIT_W-1:0] i_key_digit,
  output logic [DIGIT_W-1:0] o_disp_digit,
  output logic               o_disp_blank,
  output logic [LEN_W-1:0]   o_level,
  output logic               o_busy,
  output logic               o_win,
  output logic               o_fail
);

  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SG_TOP  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
`ifdef INPUT_TIMEOUT_EN
  localparam int CNT_TOP = (TIMEOUT_TICKS > SG_TOP) ? TIMEOUT_TICKS : SG_TOP;
`else
  localparam int CNT_TOP = SG_TOP;
`endif
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_tick_cnt;

  logic [DIGIT_W-1:0] r_disp_digit, w_disp_digit_nxt;
  logic               r_disp_blank, w_disp_blank_nxt;

  logic               w_we;
  logic [IDX_W-1:0]   w_wr_addr, w_rd_addr;
  logic [DIGIT_W-1:0] w_wr_data, w_mem_rd, w_rd_data;
  logic               w_last, w_key_match, w_show_end, w_gap_end;

  assign w_we      = (r_state == S_ADD);
  assign w_wr_addr = r_len[IDX_W-1:0];
  assign w_wr_data = fold_digit(i_rnd_digit);

  // Address is the index of the digit being compared in INPUT, or of the
  // digit about to be shown, so the display register loads in step with SHOW.
  assign w_rd_addr = (r_state == S_ADD) ? '0 :
                     (r_state == S_GAP) ? r_idx + IDX_W'(1) : r_idx;

  // First round shows the digit written in the same cycle.
  assign w_rd_data = (w_we && (w_wr_addr == w_rd_addr)) ? w_wr_data : w_mem_rd;

  assign w_last      = (LEN_W'(r_idx) == r_len - LEN_W'(1));
  assign w_key_match = (i_key_digit <= DIGIT_W'(DIGIT_MAX)) && (i_key_digit == w_rd_data);
  assign w_show_end  = (r_tick_cnt == CNT_W'(SHOW_TICKS - 1));
  assign w_gap_end   = (r_tick_cnt == CNT_W'(GAP_TICKS - 1));

  digit_sequence_game_seq_mem #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_seq_mem (
    .i_clk     (i_clk),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_mem_rd)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; a key in INPUT always takes priority over a tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_SHOW;
      S_SHOW:  if (i_tick && w_show_end) w_state_nxt = S_GAP;
      S_GAP:   if (i_tick && w_gap_end) w_state_nxt = w_last ? S_INPUT : S_SHOW;
      S_INPUT: begin
        if (i_key_valid) begin
          if (!w_key_match)                     w_state_nxt = S_FAIL;
          else if (w_last && (r_len == LEN_W'(MAX_LEN))) w_state_nxt = S_WIN;
          else if (w_last)                      w_state_nxt = S_ADD;
        end
`ifdef INPUT_TIMEOUT_EN
        else if (i_tick && (r_tick_cnt == CNT_W'(TIMEOUT_TICKS - 1))) begin
          w_state_nxt = S_FAIL;
        end
`endif
      end
      S_WIN, S_FAIL: if (i_start) w_state_nxt = S_ADD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Length, playback index and tick counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_tick_cnt <= '0;
    end else begin
      case (r_state)
        S_ADD: begin
          r_len      <= r_len + LEN_W'(1);
          r_idx      <= '0;
          r_tick_cnt <= '0;
        end
        S_SHOW: if (i_tick) r_tick_cnt <= w_show_end ? '0 : r_tick_cnt + CNT_W'(1);
        S_GAP: begin
          if (i_tick) begin
            if (w_gap_end) begin
              r_tick_cnt <= '0;
              r_idx      <= w_last ? '0 : r_idx + IDX_W'(1);
            end else begin
              r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
          end
        end
        S_INPUT: begin
          if (i_key_valid) begin
            r_tick_cnt <= '0;
            if (w_key_match && !w_last) r_idx <= r_idx + IDX_W'(1);
          end
`ifdef INPUT_TIMEOUT_EN
          else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
          end
`endif
        end
        S_WIN, S_FAIL: if (i_start) r_len <= '0;
        default: ;
      endcase
    end
  end

  // Display values for the upcoming state; the key echo holds until the next key.
  always_comb begin
    w_disp_digit_nxt = r_disp_digit;
    w_disp_blank_nxt = r_disp_blank;
    case (w_state_nxt)
      S_SHOW: begin
        w_disp_digit_nxt = w_rd_data;
        w_disp_blank_nxt = 1'b0;
      end
      S_INPUT: begin
        if ((r_state == S_INPUT) && i_key_valid) begin
          w_disp_digit_nxt = i_key_digit;
          w_disp_blank_nxt = 1'b0;
        end
      end
      default: w_disp_blank_nxt = 1'b1;
    endcase
  end

  // Registered outputs, aligned with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_disp_digit <= '0;
      r_disp_blank <= 1'b1;
      o_busy       <= 1'b0;
      o_win        <= 1'b0;
      o_fail       <= 1'b0;
    end else begin
      r_disp_digit <= w_disp_digit_nxt;
      r_disp_blank <= w_disp_blank_nxt;
      o_busy       <= (w_state_nxt == S_ADD) || (w_state_nxt == S_SHOW) || (w_state_nxt == S_GAP);
      o_win        <= (w_state_nxt == S_WIN);
      o_fail       <= (w_state_nxt == S_FAIL);
    end
  end

  assign o_disp_digit = r_disp_digit;
  assign o_disp_blank = r_disp_blank;
  assign o_level      = r_len;

endmodule
